// File: rtl/branch_predictor_pkg.sv
// Shared constants for the fetch-side branch predictor.
package branch_predictor_pkg;

  localparam int unsigned VPC_BITS_DEF = 32;
  localparam int unsigned IDX_BITS_DEF = 4;
  localparam int unsigned CNT_BITS_DEF = 32;

  localparam int unsigned PC_STEP = 4;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

endpackage

// File: rtl/branch_predictor_sat_ctr2.sv
// Next-state function of a 2-bit saturating direction counter.
module sat_ctr2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       inc,
  output logic [1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (inc) begin
      if (ctr != CTR_ST) ctr_next = ctr + 2'(1);
    end else begin
      if (ctr != CTR_SNT) ctr_next = ctr - 2'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters, trained from EX resolution,
// plus lookup / mispredict performance counters.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned VPC_BITS = VPC_BITS_DEF,
  parameter int unsigned IDX_BITS = IDX_BITS_DEF,
  parameter int unsigned CNT_BITS = CNT_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                F_valid,
  input  logic [VPC_BITS-1:0] F_pc,
  output logic                F_BP_taken,
  output logic [VPC_BITS-1:0] F_BP_target_pc,
  input  logic                EX_brn,
  input  logic [VPC_BITS-1:0] EX_pc,
  input  logic                EX_true_taken,
  input  logic [VPC_BITS-1:0] EX_alu_out,
  input  logic                EX_taken,
  output logic [CNT_BITS-1:0] BP_lookups,
  output logic [CNT_BITS-1:0] BP_mispredicts
);

  localparam int unsigned ENTRIES  = 1 << IDX_BITS;
  localparam int unsigned TAG_BITS = VPC_BITS - IDX_BITS - 2;

  logic                valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [VPC_BITS-1:0] target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];

  logic [IDX_BITS-1:0] f_idx;
  logic [TAG_BITS-1:0] f_tag;
  logic                f_hit;
  logic [IDX_BITS-1:0] ex_idx;
  logic [TAG_BITS-1:0] ex_tag;
  logic                ex_hit;
  logic [1:0]          ex_ctr_next;

  // PC alignment bits carry no information for a 4-byte aligned fetch.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{F_pc[1:0], EX_pc[1:0]};

  assign f_idx  = F_pc[IDX_BITS+1:2];
  assign f_tag  = F_pc[VPC_BITS-1:IDX_BITS+2];
  assign ex_idx = EX_pc[IDX_BITS+1:2];
  assign ex_tag = EX_pc[VPC_BITS-1:IDX_BITS+2];

  // Lookup reads the table before this cycle's update lands.
  always_comb begin
    f_hit          = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    F_BP_taken     = F_valid && f_hit && ctr_q[f_idx][1];
    F_BP_target_pc = F_BP_taken ? target_q[f_idx] : F_pc + VPC_BITS'(PC_STEP);
  end

  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  sat_ctr2 u_sat_ctr2 (
    .ctr      (ctr_q[ex_idx]),
    .inc      (EX_true_taken),
    .ctr_next (ex_ctr_next)
  );

  // Table training; a not-taken miss leaves the table untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else if (EX_brn) begin
      if (ex_hit) begin
        ctr_q[ex_idx] <= ex_ctr_next;
        if (EX_true_taken) target_q[ex_idx] <= EX_alu_out;
      end else if (EX_true_taken) begin
        valid_q[ex_idx]  <= 1'b1;
        tag_q[ex_idx]    <= ex_tag;
        target_q[ex_idx] <= EX_alu_out;
        ctr_q[ex_idx]    <= CTR_WT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      BP_lookups     <= '0;
      BP_mispredicts <= '0;
    end else begin
      if (F_valid)             BP_lookups     <= BP_lookups + CNT_BITS'(1);
      if (EX_brn && EX_taken)  BP_mispredicts <= BP_mispredicts + CNT_BITS'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized and directed checks of branch_predictor against a table-level reference model.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        F_valid;
  logic [31:0] F_pc;
  logic        F_BP_taken;
  logic [31:0] F_BP_target_pc;
  logic        EX_brn;
  logic [31:0] EX_pc;
  logic        EX_true_taken;
  logic [31:0] EX_alu_out;
  logic        EX_taken;
  logic [31:0] BP_lookups;
  logic [31:0] BP_mispredicts;

  int checks = 0;
  int errors = 0;

  // Reference model: one record per slot, counter kept as a plain integer 0..3.
  bit          m_valid [16];
  bit [31:0]   m_tag   [16];
  bit [31:0]   m_tgt   [16];
  int          m_ctr   [16];
  int unsigned m_lookups;
  int unsigned m_mispredicts;

  branch_predictor dut (
    .clk            (clk),
    .rst            (rst),
    .F_valid        (F_valid),
    .F_pc           (F_pc),
    .F_BP_taken     (F_BP_taken),
    .F_BP_target_pc (F_BP_target_pc),
    .EX_brn         (EX_brn),
    .EX_pc          (EX_pc),
    .EX_true_taken  (EX_true_taken),
    .EX_alu_out     (EX_alu_out),
    .EX_taken       (EX_taken),
    .BP_lookups     (BP_lookups),
    .BP_mispredicts (BP_mispredicts)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
      m_tgt[i]   = '0;
      m_ctr[i]   = 1;
    end
    m_lookups     = 0;
    m_mispredicts = 0;
  endfunction

  function automatic bit model_hit(input bit [31:0] pc);
    int i = int'((pc >> 2) % 16);
    return m_valid[i] && (m_tag[i] == (pc >> 6));
  endfunction

  function automatic void model_lookup(input bit fv, input bit [31:0] pc,
                                       output bit taken, output bit [31:0] tgt);
    int i = int'((pc >> 2) % 16);
    taken = fv && model_hit(pc) && (m_ctr[i] >= 2);
    tgt   = taken ? m_tgt[i] : pc + 32'd4;
  endfunction

  function automatic void model_update(input bit brn, input bit [31:0] pc,
                                       input bit tt, input bit [31:0] alu);
    int i = int'((pc >> 2) % 16);
    if (!brn) return;
    if (model_hit(pc)) begin
      if (tt) begin
        m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
        m_tgt[i] = alu;
      end else begin
        m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
      end
    end else if (tt) begin
      m_valid[i] = 1'b1;
      m_tag[i]   = pc >> 6;
      m_tgt[i]   = alu;
      m_ctr[i]   = 2;
    end
  endfunction

  // One clock: drive at negedge, check lookup, advance model at posedge, check counters.
  task automatic cycle(input bit fv, input bit [31:0] fpc, input bit brn, input bit [31:0] expc,
                       input bit tt, input bit [31:0] alu, input bit tk);
    bit        e_taken;
    bit [31:0] e_tgt;
    F_valid = fv; F_pc = fpc; EX_brn = brn; EX_pc = expc;
    EX_true_taken = tt; EX_alu_out = alu; EX_taken = tk;
    #1;
    model_lookup(fv, fpc, e_taken, e_tgt);
    check("lookup_taken", 64'(F_BP_taken), 64'(e_taken));
    check("lookup_target", 64'(F_BP_target_pc), 64'(e_tgt));
    @(posedge clk);
    model_update(brn, expc, tt, alu);
    if (fv) m_lookups++;
    if (brn && tk) m_mispredicts++;
    @(negedge clk);
    check("lookups", 64'(BP_lookups), 64'(m_lookups));
    check("mispredicts", 64'(BP_mispredicts), 64'(m_mispredicts));
  endtask

  task automatic look(input bit [31:0] fpc);
    cycle(1'b1, fpc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic train(input bit [31:0] expc, input bit tt, input bit [31:0] alu);
    cycle(1'b0, 32'h0, 1'b1, expc, tt, alu, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    F_valid = 0; F_pc = '0; EX_brn = 0; EX_pc = '0;
    EX_true_taken = 0; EX_alu_out = '0; EX_taken = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    F_pc = 32'h40; #1;
    check("rst_taken", 64'(F_BP_taken), 64'd0);
    check("rst_target", 64'(F_BP_target_pc), 64'h44);
    check("rst_lookups", 64'(BP_lookups), 64'd0);
    check("rst_mispredicts", 64'(BP_mispredicts), 64'd0);
    @(negedge clk);

    // 1: cold miss
    look(32'h100);
    check("t1_target", 64'(F_BP_target_pc), 64'h104);
    check("t1_lookups", 64'(BP_lookups), 64'd1);

    // 2: allocate on taken
    train(32'h100, 1'b1, 32'h200);
    look(32'h100);
    check("t2_taken", 64'(F_BP_taken), 64'd1);
    check("t2_target", 64'(F_BP_target_pc), 64'h200);

    // 3: decrement and saturate at strongly-not-taken
    train(32'h100, 1'b0, 32'h0);
    train(32'h100, 1'b0, 32'h0);
    look(32'h100);
    check("t3_taken", 64'(F_BP_taken), 64'd0);
    check("t3_target", 64'(F_BP_target_pc), 64'h104);
    train(32'h100, 1'b0, 32'h0);
    train(32'h100, 1'b1, 32'h240);
    look(32'h100);
    check("t3_sat_low", 64'(F_BP_taken), 64'd0);
    train(32'h100, 1'b1, 32'h280);
    look(32'h100);
    check("t3_retrain", 64'(F_BP_target_pc), 64'h280);

    // Saturate high then one not-taken keeps prediction taken
    train(32'h100, 1'b1, 32'h280);
    train(32'h100, 1'b1, 32'h280);
    train(32'h100, 1'b0, 32'h0);
    look(32'h100);
    check("sat_high", 64'(F_BP_taken), 64'd1);

    // 4: conflicting tag replaces the entry
    train(32'h140, 1'b1, 32'h300);
    look(32'h100);
    check("t4_old_miss", 64'(F_BP_target_pc), 64'h104);
    look(32'h140);
    check("t4_new_hit", 64'(F_BP_target_pc), 64'h300);

    // Not-taken miss leaves the table alone
    train(32'h100, 1'b0, 32'h0);
    look(32'h140);
    check("nt_miss_keep", 64'(F_BP_target_pc), 64'h300);

    // 5: same-slot read and write in one cycle
    cycle(1'b1, 32'h140, 1'b1, 32'h140, 1'b1, 32'h380, 1'b1);
    look(32'h140);
    check("t5_new", 64'(F_BP_target_pc), 64'h380);

    // 7: fall-through wrap
    look(32'hFFFF_FFFC);
    check("t7_wrap", 64'(F_BP_target_pc), 64'h0);

    // Random traffic over a small PC pool so hits and aliases are common
    for (int n = 0; n < 400; n++) begin
      bit [31:0] fpc, expc, alu;
      fpc  = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      expc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      if ($urandom_range(0, 7) == 0) fpc = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) expc = fpc;
      alu = $urandom & 32'hFFFF_FFFC;
      cycle(1'($urandom), fpc, 1'($urandom), expc, 1'($urandom), alu, 1'($urandom));
    end

    // 6: three mispredict cycles then an async reset pulse mid-cycle
    model_reset();
    rst = 1'b1; #1; rst = 1'b0;
    @(negedge clk);
    train(32'h100, 1'b1, 32'h200);
    for (int k = 0; k < 3; k++)
      cycle(1'b0, 32'h0, 1'b1, 32'h140, 1'b1, 32'h300, 1'b1);
    check("t6_mis3", 64'(BP_mispredicts), 64'd3);
    #2 rst = 1'b1;
    #1;
    check("t6_mis_clr", 64'(BP_mispredicts), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("t6_mis_hold", 64'(BP_mispredicts), 64'd0);
    look(32'h100);
    check("t6_empty_a", 64'(F_BP_target_pc), 64'h104);
    look(32'h140);
    check("t6_empty_b", 64'(F_BP_taken), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
